// File: rtl/psum_mem_arbiter.sv
// -----------------------------------------------------------------------------
// psum_mem_arbiter
//
// Shares one single-port partial-sum SRAM (one access per cycle) between:
//   * the convolution controller's write-back stream (never stalls, buffered
//     in a small circular FIFO and drained into the SRAM when a slot is free),
//   * the controller's accumulator read port,
//   * a host/debug readout port.
// Reads whose address matches any buffered write are held off until that
// write has drained, so every read observes all earlier writes. A wait
// counter gives the host priority over the controller read after
// HOST_MAX_WAIT bypassed cycles.
//
// Ports:
//   clk, arst_n_in          clock, asynchronous active-low reset
//   wr_valid/addr/data      write stream, accepted every cycle wr_valid = 1
//   rd_valid/addr/ready     controller read request and its grant
//   rd_rvalid               rdata holds the controller read result
//   host_valid/addr/ready   host read request and its grant
//   host_rvalid             rdata holds the host read result
//   rdata                   read data shared by both read ports
//   sram_en/we/addr/wdata   SRAM access (we = 1 write, 0 read)
//   sram_rdata              SRAM read data, one cycle after a read access
//   wbuf_level              occupied write-buffer entries
//   idle                    nothing buffered, pending or in flight
//
// Handshake: a read request is consumed in the cycle where valid and ready
// are both 1; ready is combinational from valid and the arbiter state and
// never depends on the requester waiting for it. The write stream has no
// ready: every wr_valid cycle pushes one entry.
// -----------------------------------------------------------------------------
module psum_mem_arbiter #(
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int DATA_WIDTH         = 32,
  parameter int WBUF_DEPTH         = 4,
  parameter int HOST_MAX_WAIT      = 16
) (
  input  logic                            clk,
  input  logic                            arst_n_in,
  input  logic                            wr_valid,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]           wr_data,
  input  logic                            rd_valid,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0]   rd_addr,
  output logic                            rd_ready,
  output logic                            rd_rvalid,
  input  logic                            host_valid,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0]   host_addr,
  output logic                            host_ready,
  output logic                            host_rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            sram_en,
  output logic                            sram_we,
  output logic [LOG2_OF_MEM_HEIGHT-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]           sram_wdata,
  input  logic [DATA_WIDTH-1:0]           sram_rdata,
  output logic [$clog2(WBUF_DEPTH):0]     wbuf_level,
  output logic                            idle
);

  localparam int PW = $clog2(WBUF_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = $clog2(HOST_MAX_WAIT + 1);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(WBUF_DEPTH);
  localparam logic [CW-1:0] MAX_WAIT   = CW'(HOST_MAX_WAIT);

  // Which requester owns the SRAM this cycle.
  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_DRAIN,
    SEL_RD,
    SEL_HOST
  } sel_e;

  sel_e sel;

  // Write buffer storage and bookkeeping.
  logic [LOG2_OF_MEM_HEIGHT-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0]         buf_data [WBUF_DEPTH];
  logic [PW-1:0]                 wr_ptr;
  logic [PW-1:0]                 rd_ptr;
  logic [LW-1:0]                 level;

  logic [WBUF_DEPTH-1:0]         occupied;
  logic                          rd_haz;
  logic                          host_haz;
  logic [CW-1:0]                 wait_cnt;
  logic [DATA_WIDTH-1:0]         rdata_q;
  logic                          push;
  logic                          pop;

  // A slot is occupied when its distance from the head (modulo depth)
  // is below the fill level.
  always_comb begin
    occupied = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      occupied[i] = ({1'b0, PW'(i) - rd_ptr} < level);
    end
  end

  // Hazards only look at entries already in the buffer; the write arriving
  // this cycle is ordered after any read granted this cycle.
  always_comb begin
    rd_haz   = 1'b0;
    host_haz = 1'b0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (occupied[i] && (buf_addr[i] == rd_addr))   rd_haz   = 1'b1;
      if (occupied[i] && (buf_addr[i] == host_addr)) host_haz = 1'b1;
    end
  end

  // Priority selection. A full buffer always drains first, because the
  // write stream cannot be back-pressured.
  always_comb begin
    sel = SEL_NONE;
    if (!arst_n_in) begin
      sel = SEL_NONE;
    end else if (level == FULL_LEVEL) begin
      sel = SEL_DRAIN;
    end else if (host_valid && !host_haz && (wait_cnt == MAX_WAIT)) begin
      sel = SEL_HOST;
    end else if (rd_valid && !rd_haz) begin
      sel = SEL_RD;
    end else if (host_valid && !host_haz) begin
      sel = SEL_HOST;
    end else if (level != '0) begin
      sel = SEL_DRAIN;
    end
  end

  assign rd_ready   = (sel == SEL_RD);
  assign host_ready = (sel == SEL_HOST);
  assign sram_en    = (sel != SEL_NONE);
  assign sram_we    = (sel == SEL_DRAIN);
  assign sram_wdata = buf_data[rd_ptr];

  always_comb begin
    sram_addr = buf_addr[rd_ptr];
    if (sel == SEL_RD) begin
      sram_addr = rd_addr;
    end else if (sel == SEL_HOST) begin
      sram_addr = host_addr;
    end
  end

  assign push = wr_valid;
  assign pop  = (sel == SEL_DRAIN);

  // Storage carries no reset; only the pointers/level define validity.
  always_ff @(posedge clk) begin
    if (wr_valid) begin
      buf_addr[wr_ptr] <= wr_addr;
      buf_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      rd_rvalid   <= 1'b0;
      host_rvalid <= 1'b0;
      wait_cnt    <= '0;
      rdata_q     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // Simultaneous push and pop (including when full) keeps the level.
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      rd_rvalid   <= (sel == SEL_RD);
      host_rvalid <= (sel == SEL_HOST);
      if (rd_rvalid || host_rvalid) rdata_q <= sram_rdata;
      if (!host_valid || (sel == SEL_HOST)) begin
        wait_cnt <= '0;
      end else if (wait_cnt != MAX_WAIT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Pass the SRAM word through in the result cycle, hold it afterwards.
  assign rdata = (rd_rvalid || host_rvalid) ? sram_rdata : rdata_q;

  assign wbuf_level = level;
  assign idle = (level == '0) && !rd_valid && !host_valid && !rd_rvalid && !host_rvalid;

endmodule

// File: tb/tb_psum_mem_arbiter.sv
// -----------------------------------------------------------------------------
// Bench for psum_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a queue-based
// model of the arbitration rules and a reference image of the memory.
// -----------------------------------------------------------------------------
module tb_psum_mem_arbiter;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int MAXW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic arst_n_in = 1'b0;
  always #5 clk = ~clk;

  logic          wr_valid = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          host_valid = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic          rd_ready, rd_rvalid, host_ready, host_rvalid;
  logic [DW-1:0] rdata;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [2:0]    wbuf_level;
  logic          idle;

  psum_mem_arbiter #(
    .LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH), .HOST_MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_rvalid(rd_rvalid),
    .host_valid(host_valid), .host_addr(host_addr), .host_ready(host_ready),
    .host_rvalid(host_rvalid), .rdata(rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .wbuf_level(wbuf_level), .idle(idle)
  );

  // ---------------- SRAM behavioural model ----------------
  // Output is garbage except in the cycle after a read access.
  logic [DW-1:0] sram_arr [logic [AW-1:0]];
  initial forever begin
    @(posedge clk);
    if (sram_en && sram_we) sram_arr[sram_addr] = sram_wdata;
    if (sram_en && !sram_we) sram_rdata <= sram_arr.exists(sram_addr) ? sram_arr[sram_addr] : '0;
    else sram_rdata <= $urandom;
  end

  // ---------------- counters / compare ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } went_t;

  went_t         wq[$];                       // buffered writes, oldest first
  logic [DW-1:0] mem_ref [logic [AW-1:0]];    // memory as it must be after drains
  logic [DW-1:0] exp_q[$];                    // expected data of reads in flight
  int            wcnt = 0;
  bit            m_rdv = 0, m_hrv = 0;
  logic [DW-1:0] m_rdata = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : '0;
  endfunction

  initial forever begin
    @(negedge clk);
    if (!arst_n_in) begin
      wq.delete();
      exp_q.delete();
      wcnt = 0; m_rdv = 0; m_hrv = 0; m_rdata = '0;
      chk("rst_rd_ready", rd_ready, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_sram_en", sram_en, 0);
      chk("rst_level", wbuf_level, 0);
      chk("rst_rvalids", {rd_rvalid, host_rvalid}, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_idle", idle, !rd_valid && !host_valid);
    end else begin
      bit hh, rh, dr, gr, gh;
      logic [AW-1:0] ea;
      hh = 0; rh = 0; dr = 0; gr = 0; gh = 0;
      foreach (wq[i]) begin
        if (wq[i].a == host_addr) hh = 1;
        if (wq[i].a == rd_addr)   rh = 1;
      end
      if (wq.size() == DEPTH)                       dr = 1;
      else if (host_valid && !hh && wcnt == MAXW)   gh = 1;
      else if (rd_valid && !rh)                     gr = 1;
      else if (host_valid && !hh)                   gh = 1;
      else if (wq.size() > 0)                       dr = 1;

      chk("rd_ready", rd_ready, gr);
      chk("host_ready", host_ready, gh);
      chk("sram_en", sram_en, dr | gr | gh);
      if (dr | gr | gh) begin
        ea = dr ? wq[0].a : (gr ? rd_addr : host_addr);
        chk("sram_we", sram_we, dr);
        chk("sram_addr", sram_addr, ea);
        if (dr) chk("sram_wdata", sram_wdata, wq[0].d);
      end
      if (m_rdv || m_hrv) begin
        if (exp_q.size() > 0) m_rdata = exp_q.pop_front();
      end
      chk("rd_rvalid", rd_rvalid, m_rdv);
      chk("host_rvalid", host_rvalid, m_hrv);
      chk("rdata", rdata, m_rdata);
      chk("wbuf_level", wbuf_level, wq.size());
      chk("idle", idle, (wq.size() == 0) && !rd_valid && !host_valid && !m_rdv && !m_hrv);

      // advance the model across the coming clock edge
      if (dr) begin
        mem_ref[wq[0].a] = wq[0].d;
        void'(wq.pop_front());
      end
      if (gr) exp_q.push_back(ref_rd(rd_addr));
      if (gh) exp_q.push_back(ref_rd(host_addr));
      if (wr_valid) wq.push_back('{wr_addr, wr_data});
      if (!host_valid || gh) wcnt = 0;
      else if (wcnt < MAXW) wcnt++;
      m_rdv = gr;
      m_hrv = gh;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wr_valid = 0; rd_valid = 0; host_valid = 0;
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (idle) begin
        seen = 1;
        break;
      end
    end
    chk("wait_idle_reached", seen, 1);
    tick();
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1; wr_addr = a; wr_data = d;
    tick();
    wr_valid = 0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit got);
    rd_valid = 1; rd_addr = a; got = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rd_ready) begin
        got = 1;
        break;
      end
      tick();
    end
    tick();
    rd_valid = 0;
    @(negedge clk);
    d = rdata;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [DW-1:0] d;
    bit got;
    int byp;
    bit gr, gh;
    int wprob;

    repeat (3) @(posedge clk);
    #1 arst_n_in = 1;
    wait_idle();

    // Ordered write then read of the same address.
    wr_valid = 1; wr_addr = 20'h10; wr_data = 32'hDEADBEEF;
    tick();
    wr_valid = 0; rd_valid = 1; rd_addr = 20'h10;
    @(negedge clk);
    chk("t1_hazard_holds_read", rd_ready, 0);
    chk("t1_drain_first", sram_we, 1);
    tick();
    @(negedge clk);
    chk("t1_read_granted", rd_ready, 1);
    tick();
    rd_valid = 0;
    @(negedge clk);
    chk("t1_rvalid", rd_rvalid, 1);
    chk("t1_rdata", rdata, 32'hDEADBEEF);
    tick();
    wait_idle();

    // Full buffer forces a drain ahead of a non-hazard read.
    rd_valid = 1; rd_addr = 20'h80;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1; wr_addr = AW'(i); wr_data = 32'h100 + 32'(i);
      tick();
    end
    wr_valid = 0;
    @(negedge clk);
    chk("t2_level_full", wbuf_level, 4);
    chk("t2_read_blocked", rd_ready, 0);
    chk("t2_drain_we", sram_we, 1);
    chk("t2_drain_addr", sram_addr, 0);
    tick();
    rd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      do_read(AW'(i), d, got);
      chk("t2_readback_granted", got, 1);
      chk("t2_readback", d, 32'h100 + 32'(i));
    end
    wait_idle();

    // Same-cycle read and write of one address: read sees the old word.
    do_write(20'h5, 32'h1);
    wait_idle();
    rd_valid = 1; rd_addr = 20'h5;
    wr_valid = 1; wr_addr = 20'h5; wr_data = 32'h2;
    @(negedge clk);
    chk("t3_same_cycle_grant", rd_ready, 1);
    tick();
    rd_valid = 0; wr_valid = 0;
    @(negedge clk);
    chk("t3_old_data", rdata, 32'h1);
    tick();
    do_read(20'h5, d, got);
    chk("t3_new_data", d, 32'h2);
    wait_idle();

    // Host anti-starvation under a continuous controller read stream.
    do_write(20'h7, 32'h77);
    wait_idle();
    rd_valid = 1; rd_addr = 20'h80;
    host_valid = 1; host_addr = 20'h7;
    byp = 0; got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (host_ready) begin
        got = 1;
        break;
      end
      byp++;
      tick();
    end
    chk("t4_host_granted", got, 1);
    chk("t4_bypass_count", byp, 16);
    tick();
    host_valid = 0; rd_valid = 0;
    @(negedge clk);
    chk("t4_host_rvalid", host_rvalid, 1);
    chk("t4_host_rdata", rdata, 32'h77);
    tick();
    wait_idle();

    // Randomized traffic on a small address window to provoke hazards.
    for (int c = 0; c < 3000; c++) begin
      wprob = (c / 500) % 3 == 0 ? 20 : ((c / 500) % 3 == 1 ? 50 : 90);
      @(negedge clk);
      gr = rd_ready; gh = host_ready;
      tick();
      if (!rd_valid || gr) begin
        rd_valid = ($urandom_range(0, 99) < 50);
        rd_addr = AW'($urandom_range(0, 7));
      end
      if (!host_valid || gh) begin
        host_valid = ($urandom_range(0, 99) < 30);
        host_addr = AW'($urandom_range(0, 7));
      end
      wr_valid = ($urandom_range(0, 99) < wprob);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
    end
    clear_inputs();
    wait_idle();

    // Reset in the middle of operation discards buffered writes.
    rd_valid = 1; rd_addr = 20'h80;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_addr = 20'h20 + AW'(i); wr_data = 32'hA0 + 32'(i);
      tick();
    end
    wr_valid = 0;
    #1 arst_n_in = 0;
    #1;
    chk("t5_level_cleared", wbuf_level, 0);
    chk("t5_rvalid_cleared", rd_rvalid, 0);
    chk("t5_sram_en_off", sram_en, 0);
    chk("t5_grant_off", rd_ready, 0);
    rd_valid = 0;
    tick();
    tick();
    arst_n_in = 1;
    @(negedge clk);
    chk("t5_idle_after_release", idle, 1);
    tick();
    do_read(20'h20, d, got);
    chk("t5_write_discarded", d, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/psum_mem_arbiter.md
Name: psum_mem_arbiter

Overview:
- Shares the single-port partial-sum SRAM between three requesters. Each SRAM access costs one cycle.
- Requesters:
  - the convolution controller's pipelined write-back stream, which cannot stall and is buffered;
  - the controller's accumulator read;
  - a host/debug readout port.
- Preserves read-after-write ordering per address. Prevents host starvation.

Parameters:
- LOG2_OF_MEM_HEIGHT, 20, SRAM address width.
- DATA_WIDTH, 32, partial-sum word width.
- WBUF_DEPTH, 4, write-buffer entries; power of 2, at least 2.
- HOST_MAX_WAIT, 16, cycles a pending host request may be bypassed before it gets priority over the controller read.

Ports:
- clk  in  1  clock.
- arst_n_in  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  controller write request; always accepted.
- wr_addr  in  LOG2_OF_MEM_HEIGHT  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_valid  in  1  controller read request.
- rd_addr  in  LOG2_OF_MEM_HEIGHT  controller read address.
- rd_ready  out  1  controller read granted this cycle.
- rd_rvalid  out  1  rdata holds the controller read result.
- host_valid  in  1  host read request.
- host_addr  in  LOG2_OF_MEM_HEIGHT  host read address.
- host_ready  out  1  host read granted this cycle.
- host_rvalid  out  1  rdata holds the host read result.
- rdata  out  DATA_WIDTH  read data, shared by both read ports.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write (1) or read (0).
- sram_addr  out  LOG2_OF_MEM_HEIGHT  SRAM address.
- sram_wdata  out  DATA_WIDTH  SRAM write data.
- sram_rdata  in  DATA_WIDTH  SRAM read data, valid one cycle after a read access.
- wbuf_level  out  $clog2(WBUF_DEPTH)+1  number of occupied write-buffer entries.
- idle  out  1  write buffer empty, no read in flight, no request pending.

Behaviour:
- Reset: buffer pointers and level = 0, rd_rvalid = host_rvalid = 0, wait counter = 0, rdata = 0. While arst_n_in is low, all grants and sram_en are forced to 0. Reset mid-operation discards buffered writes.
- Write buffer: circular FIFO of {addr, data}.
  - A write is pushed at the clock edge whenever wr_valid = 1.
  - Push and pop may occur in the same cycle, including when the buffer is full. The level then stays unchanged, so the buffer never overflows.
  - No same-cycle bypass: an entry pushed into an empty buffer is drained at the earliest in the next cycle.
- Hazard check:
  - A read request is hazardous when its address equals the address of any occupied buffer entry.
  - The write arriving in the same cycle is ordered after the read and is not checked.
  - A hazardous requester is not granted; the buffer drains until the matching entry is gone.
- Per-cycle priority (exactly one winner, or none):
  1. Level == WBUF_DEPTH: drain the buffer head.
  2. host_valid, no host hazard, and wait counter == HOST_MAX_WAIT: host read.
  3. rd_valid and no controller hazard: controller read.
  4. host_valid and no host hazard: host read.
  5. Level > 0: drain the buffer head.
  6. Otherwise: sram_en = 0.
- Grants: rd_ready and host_ready are combinational and mutually exclusive. A request is consumed in the cycle its ready is 1.
- Drain cycle: sram_en = 1, sram_we = 1, sram_addr/sram_wdata = head entry, head pointer advances.
- Read grant: sram_en = 1, sram_we = 0, sram_addr = requester address.
- Read latency is 1 cycle: rd_rvalid or host_rvalid is registered from the grant. rdata = sram_rdata in that following cycle and holds its value otherwise.
- Wait counter:
  - Increments, saturating at HOST_MAX_WAIT, each cycle host_valid = 1 and host_ready = 0.
  - Clears on a host grant or when host_valid = 0.
- idle = (level == 0) && !rd_valid && !host_valid && !rd_rvalid && !host_rvalid.

Test Plan:
- Ordered write then read: write addr 0x10 = 0xDEADBEEF, next cycle rd_valid to 0x10 -> rd_ready low until the drain write occurs, then grant; rd_rvalid one cycle later with rdata = 0xDEADBEEF.
- Full-buffer drain: writes to 0..3 back-to-back with rd_valid held (non-hazard addr 0x80), WBUF_DEPTH = 4 -> buffer reaches level 4; the next cycle's grant is a drain, not the read; no write lost (readback of 0..3 correct).
- Same-cycle ordering: SRAM addr 5 = 0x1; issue rd_valid addr 5 together with wr_valid addr 5 data 0x2, buffer empty -> read granted and returns 0x1; a later read returns 0x2.
- Host anti-starvation: rd_valid held continuously, host_valid addr 7 -> host_ready asserted exactly after 16 bypassed cycles; host_rvalid next cycle with the correct data.
- Reset mid-operation: three buffered writes, then assert arst_n_in low -> wbuf_level = 0, rvalids = 0, sram_en = 0 immediately; after release idle = 1.
